strobe_generator_multi: RTL and testbench

//  Multi-channel periodic strobe source with runtime-programmable period per channel.

---
 rtl/strobe_defs.sv | 13 +
 rtl/strobe_channel.sv | 132 +++++++++++++
 rtl/strobe_generator_multi.sv | 38 +++
 tb/tb_strobe_generator_multi.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/strobe_defs.sv
// Shared definitions for the multi-channel strobe generator.
// Mode and channel state encodings used by every channel.
package strobe_defs;

  localparam logic MODE_CONTINUOUS = 1'b0;
  localparam logic MODE_BURST      = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_t;

endpackage

// File: rtl/strobe_channel.sv
// One strobe channel: period down-counter plus burst FSM.
// All outputs are registered.
module strobe_channel
  import strobe_defs::*;
#(
  parameter int PERIOD_WIDTH = 16,
  parameter int BURST_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    mode,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic [BURST_WIDTH-1:0]  burst_count,
  input  logic                    start,
  output logic                    strobe,
  output logic                    busy,
  output logic                    done
);

  localparam int PW = PERIOD_WIDTH;
  localparam int BW = BURST_WIDTH;

  ch_state_t      state_q;
  ch_state_t      state_d;
  logic           mode_q;
  logic           mode_d;
  logic [PW-1:0]  cnt_q;
  logic [PW-1:0]  cnt_d;
  logic [PW-1:0]  cnt_cur;
  logic [PW-1:0]  reload_val;
  logic [BW-1:0]  rem_q;
  logic [BW-1:0]  rem_d;

  logic run_burst;
  logic tick;
  logic last;
  logic en_idle;
  logic en_burst;
  logic en_cont;
  logic en_arm;
  logic fin;
  logic strobe_d;
  logic busy_d;
  logic done_d;

  assign reload_val = (period == '0) ? '0
                    : period - PW'(1);

  // Outside RUN the counter reads as P-1 of the
  // live period, so reset and idle need no load.
  assign cnt_cur   = (state_q == ST_RUN) ? cnt_q
                   : reload_val;
  assign run_burst = (state_q == ST_RUN) &&
                     (mode_q == MODE_BURST);
  assign tick      = (cnt_cur == '0);
  assign last      = (rem_q == BW'(1));

  assign en_idle  = !enable;
  assign en_burst = enable && run_burst;
  assign en_cont  = enable && !run_burst &&
                    (mode == MODE_CONTINUOUS);
  assign en_arm   = enable && !run_burst &&
                    (mode == MODE_BURST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_CONTINUOUS;
      cnt_q   <= '0;
      rem_q   <= '0;
      strobe  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      strobe  <= strobe_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    mode_d  = mode_q;
    cnt_d   = reload_val;
    rem_d   = rem_q;
    unique case (1'b1)
      en_idle: begin
        state_d = ST_IDLE;
      end
      en_burst: begin
        state_d = (tick && last) ? ST_IDLE
                : ST_RUN;
        cnt_d   = tick ? reload_val
                : cnt_cur - PW'(1);
        if (tick) begin
          rem_d = rem_q - BW'(1);
        end
      end
      en_cont: begin
        state_d = ST_RUN;
        mode_d  = MODE_CONTINUOUS;
        cnt_d   = tick ? reload_val
                : cnt_cur - PW'(1);
      end
      en_arm: begin
        if (start && (burst_count != '0)) begin
          state_d = ST_RUN;
          mode_d  = MODE_BURST;
          rem_d   = burst_count;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Busy stays up through the Done cycle of a burst.
  always_comb begin
    fin      = en_burst && tick && last;
    strobe_d = (en_burst || en_cont) && tick;
    done_d   = fin || (en_arm && start &&
                       (burst_count == '0));
    busy_d   = (state_d == ST_RUN) || fin;
  end

endmodule

// File: rtl/strobe_generator_multi.sv
// Multi-channel programmable strobe source.
// Replicates one independent channel per bus slice.
module strobe_generator_multi #(
  parameter int CHANNELS     = 4,
  parameter int PERIOD_WIDTH = 16,
  parameter int BURST_WIDTH  = 8
) (
  input  logic                             Clock,
  input  logic                             Reset,
  input  logic [CHANNELS-1:0]              Enable_i,
  input  logic [CHANNELS-1:0]              Mode_i,
  input  logic [CHANNELS*PERIOD_WIDTH-1:0] Period_i,
  input  logic [CHANNELS*BURST_WIDTH-1:0]  BurstCount_i,
  input  logic [CHANNELS-1:0]              Start_i,
  output logic [CHANNELS-1:0]              Strobe_o,
  output logic [CHANNELS-1:0]              Busy_o,
  output logic [CHANNELS-1:0]              Done_o
);

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    strobe_channel #(
      .PERIOD_WIDTH(PERIOD_WIDTH),
      .BURST_WIDTH (BURST_WIDTH)
    ) u_ch (
      .clk        (Clock),
      .rst_n      (Reset),
      .enable     (Enable_i[n]),
      .mode       (Mode_i[n]),
      .period     (Period_i[n*PERIOD_WIDTH +: PERIOD_WIDTH]),
      .burst_count(BurstCount_i[n*BURST_WIDTH +: BURST_WIDTH]),
      .start      (Start_i[n]),
      .strobe     (Strobe_o[n]),
      .busy       (Busy_o[n]),
      .done       (Done_o[n])
    );
  end

endmodule

// File: tb/tb_strobe_generator_multi.sv
// Bench for strobe_generator_multi: directed cases
// plus random stimulus against a tick-counting model.
module tb_strobe_generator_multi;

  localparam int CH = 4;
  localparam int PW = 16;
  localparam int BW = 8;

  logic              Clock = 1'b0;
  logic              Reset;
  logic [CH-1:0]     Enable_i;
  logic [CH-1:0]     Mode_i;
  logic [CH*PW-1:0]  Period_i;
  logic [CH*BW-1:0]  BurstCount_i;
  logic [CH-1:0]     Start_i;
  logic [CH-1:0]     Strobe_o;
  logic [CH-1:0]     Busy_o;
  logic [CH-1:0]     Done_o;

  strobe_generator_multi #(
    .CHANNELS    (CH),
    .PERIOD_WIDTH(PW),
    .BURST_WIDTH (BW)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Enable_i    (Enable_i),
    .Mode_i      (Mode_i),
    .Period_i    (Period_i),
    .BurstCount_i(BurstCount_i),
    .Start_i     (Start_i),
    .Strobe_o    (Strobe_o),
    .Busy_o      (Busy_o),
    .Done_o      (Done_o)
  );

  always #5 Clock = ~Clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  // Model: count enabled ticks since the last
  // period boundary; strobe when the count hits P.
  bit            m_run  [CH];
  bit            m_bm   [CH];
  int            m_k    [CH];
  int            m_p    [CH];
  int            m_left [CH];
  logic [CH-1:0] es;
  logic [CH-1:0] eb;
  logic [CH-1:0] ed;

  function automatic int eff(input int ch);
    int v;
    v = int'(Period_i[ch*PW +: PW]);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_run[c] = 0;
      m_bm[c]  = 0;
      m_k[c]   = 0;
      m_p[c]   = 1;
      m_left[c] = 0;
    end
    es = '0;
    eb = '0;
    ed = '0;
  endtask

  task automatic model_edge();
    for (int c = 0; c < CH; c++) begin
      bit s;
      bit d;
      bit fin;
      int bc;
      s   = 0;
      d   = 0;
      fin = 0;
      bc  = int'(BurstCount_i[c*BW +: BW]);
      if (!Enable_i[c]) begin
        m_run[c] = 0;
      end else if (m_run[c] && m_bm[c]) begin
        m_k[c]++;
        if (m_k[c] == m_p[c]) begin
          s = 1;
          m_k[c] = 0;
          m_p[c] = eff(c);
          m_left[c]--;
          if (m_left[c] == 0) begin
            d = 1;
            fin = 1;
            m_run[c] = 0;
          end
        end
      end else if (!Mode_i[c]) begin
        if (!m_run[c]) begin
          m_run[c] = 1;
          m_bm[c]  = 0;
          m_k[c]   = 0;
          m_p[c]   = eff(c);
        end
        m_k[c]++;
        if (m_k[c] == m_p[c]) begin
          s = 1;
          m_k[c] = 0;
          m_p[c] = eff(c);
        end
      end else begin
        m_run[c] = 0;
        if (Start_i[c]) begin
          if (bc == 0) begin
            d = 1;
          end else begin
            m_run[c]  = 1;
            m_bm[c]   = 1;
            m_k[c]    = 0;
            m_p[c]    = eff(c);
            m_left[c] = bc;
          end
        end
      end
      es[c] = s;
      ed[c] = d;
      eb[c] = m_run[c] | fin;
    end
  endtask

  task automatic step();
    @(posedge Clock);
    model_edge();
    @(negedge Clock);
    check("strobe", 32'(Strobe_o), 32'(es));
    check("busy", 32'(Busy_o), 32'(eb));
    check("done", 32'(Done_o), 32'(ed));
  endtask

  task automatic async_reset();
    #1 Reset = 1'b0;
    #1;
    check("rst_strobe", 32'(Strobe_o), 0);
    check("rst_busy", 32'(Busy_o), 0);
    check("rst_done", 32'(Done_o), 0);
    model_reset();
    #1 Reset = 1'b1;
  endtask

  task automatic set_p(input int c, input int v);
    Period_i[c*PW +: PW] = PW'(v);
  endtask

  task automatic set_bc(input int c, input int v);
    BurstCount_i[c*BW +: BW] = BW'(v);
  endtask

  task automatic start0();
    Start_i[0] = 1'b1;
    step();
    Start_i[0] = 1'b0;
  endtask

  initial begin
    int cnt;
    int sum;
    int dpos;
    int n;
    int tot [CH];
    Reset        = 1'b1;
    Enable_i     = '0;
    Mode_i       = '0;
    Start_i      = '0;
    Period_i     = '0;
    BurstCount_i = '0;
    model_reset();
    #1 Reset = 1'b0;
    #1;
    check("reset_strobe", 32'(Strobe_o), 0);
    check("reset_busy", 32'(Busy_o), 0);
    check("reset_done", 32'(Done_o), 0);
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b1;

    // continuous, period 10
    set_p(0, 10);
    Enable_i[0] = 1'b1;
    cnt = 0;
    sum = 0;
    for (int i = 1; i <= 35; i++) begin
      step();
      if (Strobe_o[0]) begin
        cnt++;
        sum += i;
      end
    end
    check("t1_count", cnt, 3);
    check("t1_pos", sum, 60);
    check("t1_busy", 32'(Busy_o[0]), 1);
    Enable_i[0] = 1'b0;
    step();

    // period 0 and 1 strobe every cycle
    set_p(0, 0);
    Enable_i[0] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      cnt += int'(Strobe_o[0]);
    end
    check("t2_p0", cnt, 5);
    set_p(0, 1);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      cnt += int'(Strobe_o[0]);
    end
    check("t2_p1", cnt, 5);
    Enable_i[0] = 1'b0;
    step();

    // period 3 -> 5 mid-period
    set_p(0, 3);
    Enable_i[0] = 1'b1;
    cnt = 0;
    sum = 0;
    for (int i = 1; i <= 13; i++) begin
      if (i == 3) set_p(0, 5);
      step();
      if (Strobe_o[0]) begin
        cnt++;
        sum += i;
      end
    end
    check("t2_chg_count", cnt, 3);
    check("t2_chg_pos", sum, 24);
    Enable_i[0] = 1'b0;
    step();

    // burst of 3, period 4
    Mode_i[0] = 1'b1;
    set_p(0, 4);
    set_bc(0, 3);
    Enable_i[0] = 1'b1;
    step();
    start0();
    cnt = 0;
    sum = 0;
    dpos = 0;
    for (int i = 1; i <= 14; i++) begin
      step();
      if (Strobe_o[0]) begin
        cnt++;
        sum += i;
      end
      if (Done_o[0]) dpos = i;
      if (i == 12) check("t3_busy_hi",
                         32'(Busy_o[0]), 1);
      if (i == 13) check("t3_busy_lo",
                         32'(Busy_o[0]), 0);
    end
    check("t3_count", cnt, 3);
    check("t3_pos", sum, 24);
    check("t3_done", dpos, 12);

    // burst count 0
    set_bc(0, 0);
    start0();
    check("t3_bc0_done", 32'(Done_o[0]), 1);
    check("t3_bc0_strobe", 32'(Strobe_o[0]), 0);
    step();
    check("t3_bc0_after", 32'(Done_o[0]), 0);

    // restart ignored while running
    set_bc(0, 3);
    start0();
    cnt = 0;
    for (int i = 1; i <= 16; i++) begin
      Start_i[0] = (i == 5);
      step();
      cnt += int'(Strobe_o[0]);
    end
    Start_i[0] = 1'b0;
    check("t4_restart", cnt, 3);

    // enable drop after strobe 2
    start0();
    n = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      step();
      n += int'(Strobe_o[0]);
    end
    check("t4_two", n, 2);
    Enable_i[0] = 1'b0;
    cnt = 0;
    dpos = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      cnt += int'(Strobe_o[0]);
      dpos += int'(Done_o[0]);
    end
    check("t4_abort_strobe", cnt, 0);
    check("t4_abort_done", dpos, 0);
    check("t4_abort_busy", 32'(Busy_o[0]), 0);

    // async reset mid-burst
    Enable_i[0] = 1'b1;
    start0();
    for (int i = 0; i < 5; i++) step();
    check("t5_busy_pre", 32'(Busy_o[0]), 1);
    async_reset();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      cnt += int'(Strobe_o[0]) + int'(Busy_o[0]);
    end
    check("t5_idle", cnt, 0);

    // four channels, periods 2/3/5/7
    Enable_i = '0;
    Mode_i   = '0;
    step();
    set_p(0, 2);
    set_p(1, 3);
    set_p(2, 5);
    set_p(3, 7);
    Enable_i = '1;
    for (int c = 0; c < CH; c++) tot[c] = 0;
    for (int i = 0; i < 210; i++) begin
      step();
      for (int c = 0; c < CH; c++)
        tot[c] += int'(Strobe_o[c]);
    end
    check("t6_ch0", tot[0], 105);
    check("t6_ch1", tot[1], 70);
    check("t6_ch2", tot[2], 42);
    check("t6_ch3", tot[3], 30);

    // random traffic on all channels
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 15) == 0)
          Enable_i[c] = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 39) == 0)
          Mode_i[c] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 19) == 0)
          set_p(c, int'($urandom_range(0, 6)));
        if ($urandom_range(0, 19) == 0)
          set_bc(c, int'($urandom_range(0, 4)));
        Start_i[c] = ($urandom_range(0, 9) == 0);
      end
      if ($urandom_range(0, 799) == 0)
        async_reset();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
